// File: rtl/kfpga_config_pkg.sv
// kfpga_config_pkg: loader FSM states and default configuration-chain geometry
package kfpga_config_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SHIFT, DONE} state_t;
  localparam int DEFAULT_CHAIN_LENGTH = 34688;
  localparam int DEFAULT_WORD_WIDTH = 32;
endpackage

// File: rtl/config_loader_if.sv
// config_loader_if: control, bitstream-word and core-config signals of the loader
//   master drives start/abort/word_data/word_valid; slave (the loader) drives the rest
interface config_loader_if import kfpga_config_pkg::*; #(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
);
  logic start;
  logic abort;
  logic [WORD_WIDTH-1:0] word_data;
  logic word_valid;
  logic word_ready;
  logic config_out;
  logic config_enable;
  logic config_nreset;
  logic core_nreset;
  logic busy;
  logic done;
  modport master (
    output start, abort, word_data, word_valid,
    input word_ready, config_out, config_enable, config_nreset, core_nreset, busy, done
  );
  modport slave (
    input start, abort, word_data, word_valid,
    output word_ready, config_out, config_enable, config_nreset, core_nreset, busy, done
  );
endinterface

// File: rtl/config_shifter.sv
// config_shifter: parallel-load, LSB-first serial-out word register with word and chain bit counters
//   clr clears everything, load captures data, shift moves one bit out
//   bit_out = register bit 0; word_last / chain_last flag the final bit of a word / of the chain
module config_shifter import kfpga_config_pkg::*; #(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int CHAIN_LENGTH = DEFAULT_CHAIN_LENGTH
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] data,
  output logic                  bit_out,
  output logic                  word_last,
  output logic                  chain_last
);
  localparam int BW = WORD_WIDTH > 1 ? $clog2(WORD_WIDTH) : 1;
  localparam int TW = $clog2(CHAIN_LENGTH + 1);
  logic [WORD_WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [TW-1:0] total_q, total_d;
  always_comb begin
    sr_d = clr ? '0 : load ? data : shift ? sr_q >> 1 : sr_q;
    bit_d = (clr || load) ? '0 : shift ? bit_q + 1'b1 : bit_q;
    total_d = clr ? '0 : shift ? total_q + 1'b1 : total_q;
  end
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      sr_q <= '0;
      bit_q <= '0;
      total_q <= '0;
    end else begin
      sr_q <= sr_d;
      bit_q <= bit_d;
      total_q <= total_d;
    end
  end
  assign bit_out = sr_q[0];
  assign word_last = bit_q == BW'(WORD_WIDTH - 1);
  // chain_last cuts the final word short when CHAIN_LENGTH is not a word multiple
  assign chain_last = total_q == TW'(CHAIN_LENGTH - 1);
endmodule

// File: rtl/config_loader.sv
// config_loader: streams bitstream words serially into a core configuration chain
//   clock/nreset: single clock, async active-low reset
//   bus (slave): start/abort control, word_data/word_valid/word_ready stream,
//   config_out/config_enable/config_nreset/core_nreset to the core, busy/done status
module config_loader import kfpga_config_pkg::*; #(
  parameter int CHAIN_LENGTH = DEFAULT_CHAIN_LENGTH,
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int CLEAR_CYCLES = 4
) (
  input logic            clock,
  input logic            nreset,
  config_loader_if.slave bus
);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  state_t state_q, state_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic cfg_nrst_q, cfg_nrst_d;
  logic busy, cancel, go, accept, shift, clr, bit_out, word_last, chain_last;
  assign busy = state_q inside {CLEAR, LOAD, SHIFT};
  assign cancel = bus.abort && busy;
  // abort beats a simultaneous start even where abort itself has no effect
  assign go = bus.start && !bus.abort;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = go ? CLEAR : IDLE;
      CLEAR:   state_d = clr_cnt_q == CW'(CLEAR_CYCLES - 1) ? LOAD : CLEAR;
      LOAD:    state_d = bus.word_valid ? SHIFT : LOAD;
      SHIFT:   state_d = chain_last ? DONE : word_last ? LOAD : SHIFT;
      DONE:    state_d = go ? CLEAR : DONE;
      default: state_d = IDLE;
    endcase
    if (cancel) state_d = IDLE;
    clr_cnt_d = (state_q == CLEAR && state_d == CLEAR) ? clr_cnt_q + 1'b1 : '0;
    // registered from the next state so it is low during reset and rises on the first edge after
    cfg_nrst_d = state_d != CLEAR;
  end
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      clr_cnt_q <= '0;
      cfg_nrst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_cnt_q <= clr_cnt_d;
      cfg_nrst_q <= cfg_nrst_d;
    end
  end
  assign accept = state_q == LOAD && bus.word_valid && !cancel;
  assign shift = state_q == SHIFT && !cancel;
  // counters only live across LOAD/SHIFT; every other state starts the next load from zero
  assign clr = cancel || !(state_q inside {LOAD, SHIFT});
  config_shifter #(.WORD_WIDTH(WORD_WIDTH), .CHAIN_LENGTH(CHAIN_LENGTH)) u_shifter (
    .clock(clock),
    .nreset(nreset),
    .clr(clr),
    .load(accept),
    .shift(shift),
    .data(bus.word_data),
    .bit_out(bit_out),
    .word_last(word_last),
    .chain_last(chain_last)
  );
  assign bus.word_ready = state_q == LOAD;
  assign bus.config_enable = state_q == SHIFT;
  assign bus.config_out = state_q == SHIFT && bit_out;
  assign bus.config_nreset = cfg_nrst_q;
  assign bus.core_nreset = state_q == DONE;
  assign bus.busy = busy;
  assign bus.done = state_q == DONE;
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed table and load sequences for config_loader at chain lengths 40, 64 and default
module tb_config_loader;
  logic clk = 1'b0;
  logic nreset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic word_valid = 1'b0;
  logic [31:0] word_data = '0;
  int sel = 0;
  int checks = 0;
  int failures = 0;
  int ce_n, wr_n, clr_n, acc_n, viol;
  logic timeout;
  logic [31:0] words[$];
  bit got[$];
  always #5 clk = ~clk;
  config_loader_if #(.WORD_WIDTH(32)) ifa ();
  config_loader_if #(.WORD_WIDTH(32)) ifb ();
  config_loader_if #(.WORD_WIDTH(32)) ifc ();
  assign ifa.start = start && sel == 0;
  assign ifb.start = start && sel == 1;
  assign ifc.start = start && sel == 2;
  assign ifa.abort = abort && sel == 0;
  assign ifb.abort = abort && sel == 1;
  assign ifc.abort = abort && sel == 2;
  assign ifa.word_valid = word_valid;
  assign ifb.word_valid = word_valid;
  assign ifc.word_valid = word_valid;
  assign ifa.word_data = word_data;
  assign ifb.word_data = word_data;
  assign ifc.word_data = word_data;
  config_loader #(.CHAIN_LENGTH(40), .WORD_WIDTH(32), .CLEAR_CYCLES(4)) u_a (.clock(clk), .nreset(nreset), .bus(ifa));
  config_loader #(.CHAIN_LENGTH(64), .WORD_WIDTH(32), .CLEAR_CYCLES(4)) u_b (.clock(clk), .nreset(nreset), .bus(ifb));
  config_loader u_c (.clock(clk), .nreset(nreset), .bus(ifc));
  // output vector order: {word_ready, config_out, config_enable, config_nreset, core_nreset, busy, done}
  logic [6:0] oa, ob, oc, outs;
  assign oa = {ifa.word_ready, ifa.config_out, ifa.config_enable, ifa.config_nreset, ifa.core_nreset, ifa.busy, ifa.done};
  assign ob = {ifb.word_ready, ifb.config_out, ifb.config_enable, ifb.config_nreset, ifb.core_nreset, ifb.busy, ifb.done};
  assign oc = {ifc.word_ready, ifc.config_out, ifc.config_enable, ifc.config_nreset, ifc.core_nreset, ifc.busy, ifc.done};
  assign outs = sel == 0 ? oa : sel == 1 ? ob : oc;
  localparam logic [6:0] S_IDLE = 7'b0001000;
  localparam logic [6:0] S_CLEAR = 7'b0000010;
  localparam logic [6:0] S_LOAD = 7'b1001010;
  localparam logic [6:0] S_SH1 = 7'b0111010;
  localparam logic [6:0] S_SH0 = 7'b0011010;
  localparam logic [6:0] S_DONE = 7'b0001101;
  typedef struct {
    logic st;
    logic ab;
    logic vld;
    logic [31:0] dat;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[20];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int stream_errs();
    int e = 0;
    logic [31:0] w;
    for (int k = 0; k < got.size(); k++) begin
      w = words[k / 32];
      if (got[k] != w[k % 32]) e++;
    end
    return e;
  endfunction
  function automatic logic [31:0] pack(input int from, input int n);
    logic [31:0] p = '0;
    for (int i = 0; i < n; i++) if (from + i < got.size()) p[i] = got[from + i];
    return p;
  endfunction
  // Pulses start, then feeds words when ready (with random stalls up to gapmax), records the serial
  // stream and returns at the first sample where busy has dropped (or when the budget runs out).
  task automatic run_load(input int gapmax, input int abort_at, input bit noise, input int budget);
    int idx = 0;
    int gap = $urandom_range(0, gapmax);
    got.delete();
    ce_n = 0; wr_n = 0; clr_n = 0; acc_n = 0; viol = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (!outs[1]) break;
      if (!outs[3]) clr_n++;
      if (outs[6]) wr_n++;
      if (outs[4]) begin
        got.push_back(outs[5]);
        ce_n++;
      end
      if (!outs[4] && outs[5]) viol++;
      if (outs[4] && outs[6]) viol++;
      if (outs[4] && outs[2]) viol++;
      abort = outs[4] && (ce_n - 1 == abort_at);
      start = noise && outs[4];
      word_valid = 1'b0;
      if (outs[6] && idx < words.size()) begin
        if (gap > 0) gap--;
        else begin
          word_valid = 1'b1;
          word_data = words[idx];
          idx++;
          acc_n++;
          gap = $urandom_range(0, gapmax);
        end
      end
      @(negedge clk);
    end
    timeout = outs[1];
    start = 1'b0;
    abort = 1'b0;
    word_valid = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{0, 0, 0, 32'h0, S_IDLE};
    tbl[1]  = '{0, 1, 0, 32'h0, S_IDLE};
    tbl[2]  = '{1, 1, 0, 32'h0, S_IDLE};
    tbl[3]  = '{1, 0, 0, 32'h0, S_CLEAR};
    tbl[4]  = '{1, 0, 0, 32'h0, S_CLEAR};
    tbl[5]  = '{0, 0, 0, 32'h0, S_CLEAR};
    tbl[6]  = '{0, 0, 0, 32'h0, S_CLEAR};
    tbl[7]  = '{0, 0, 0, 32'h0, S_LOAD};
    tbl[8]  = '{0, 0, 0, 32'h0, S_LOAD};
    tbl[9]  = '{0, 0, 1, 32'hFFFF_FFFE, S_SH0};
    tbl[10] = '{1, 0, 0, 32'h0, S_SH1};
    tbl[11] = '{1, 1, 0, 32'h0, S_IDLE};
    tbl[12] = '{1, 0, 0, 32'h0, S_CLEAR};
    tbl[13] = '{0, 1, 0, 32'h0, S_IDLE};
    tbl[14] = '{1, 0, 0, 32'h0, S_CLEAR};
    tbl[15] = '{0, 0, 0, 32'h0, S_CLEAR};
    tbl[16] = '{0, 0, 0, 32'h0, S_CLEAR};
    tbl[17] = '{0, 0, 0, 32'h0, S_CLEAR};
    tbl[18] = '{0, 0, 0, 32'h0, S_LOAD};
    tbl[19] = '{0, 1, 0, 32'h0, S_IDLE};
    #1 nreset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs, 7'b0);
    nreset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start = tbl[i].st;
      abort = tbl[i].ab;
      word_valid = tbl[i].vld;
      word_data = tbl[i].dat;
      @(negedge clk);
      chk($sformatf("table_%0d", i), outs, tbl[i].exp);
    end
    start = 1'b0; abort = 1'b0; word_valid = 1'b0;
    // 40-bit chain: second word truncated to its low 8 bits, start held during SHIFT
    words = '{32'hFFFF_FFFF, 32'h0000_00F3};
    run_load(0, -1, 1'b1, 300);
    chk("c40_timeout", timeout, 0);
    chk("c40_enable_cycles", ce_n, 40);
    chk("c40_ready_cycles", wr_n, 2);
    chk("c40_clear_cycles", clr_n, 4);
    chk("c40_last8", pack(32, 8), 32'hF3);
    chk("c40_stream", stream_errs(), 0);
    chk("c40_protocol", viol, 0);
    chk("c40_done_state", outs, S_DONE);
    sel = 1;
    words = '{32'hA5A5_A5A5, 32'h0000_FFFF};
    run_load(0, -1, 1'b0, 300);
    chk("c64_timeout", timeout, 0);
    chk("c64_enable_cycles", ce_n, 64);
    chk("c64_ready_cycles", wr_n, 2);
    chk("c64_first8", pack(0, 8), 32'hA5);
    chk("c64_last32", pack(32, 32), 32'h0000_FFFF);
    chk("c64_stream", stream_errs(), 0);
    chk("c64_protocol", viol, 0);
    chk("c64_done_state", outs, S_DONE);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("c64_reload_clear", outs, S_CLEAR);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("c64_abort_clear", outs, S_IDLE);
    // default chain: abort at bit 10 of the third word, then a full load with stalls
    sel = 2;
    words.delete();
    for (int i = 0; i < 1084; i++) words.push_back($urandom);
    run_load(2, 74, 1'b0, 1000);
    chk("dflt_abort_timeout", timeout, 0);
    chk("dflt_abort_enables", ce_n, 75);
    chk("dflt_abort_state", outs, S_IDLE);
    chk("dflt_abort_stream", stream_errs(), 0);
    run_load(3, -1, 1'b0, 34688 + 1084 * 6 + 100);
    chk("dflt_timeout", timeout, 0);
    chk("dflt_enable_cycles", ce_n, 34688);
    chk("dflt_words", acc_n, 1084);
    chk("dflt_clear_cycles", clr_n, 4);
    chk("dflt_stream", stream_errs(), 0);
    chk("dflt_protocol", viol, 0);
    chk("dflt_done_state", outs, S_DONE);
    // asynchronous reset in the middle of SHIFT, then a clean reload
    sel = 0;
    word_valid = 1'b1;
    word_data = 32'hFFFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && !outs[4]; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rst_in_shift", outs, S_SH1);
    #1 nreset = 1'b0;
    #1 chk("rst_async_outputs", outs, 7'b0);
    word_valid = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chk("rst_release_idle", outs, S_IDLE);
    words = '{32'hFFFF_FFFF, 32'h0000_00F3};
    run_load(1, -1, 1'b0, 300);
    chk("rst_reload_enables", ce_n, 40);
    chk("rst_reload_stream", stream_errs(), 0);
    chk("rst_reload_done", outs, S_DONE);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter CHAIN_LENGTH, default 34688: total bits in the core configuration chain.
REQ-002 Parameter WORD_WIDTH, default 32: bitstream word width.
REQ-003 Parameter CLEAR_CYCLES, default 4: cycles config_nreset is held low before shifting.
REQ-004 clock  in  1  single clock for all logic.
REQ-005 nreset  in  1  asynchronous reset, active-low.
REQ-006 start  in  1  one-cycle request to begin a full chain load.
REQ-007 abort  in  1  one-cycle request to cancel the load in progress.
REQ-008 word_data  in  WORD_WIDTH  bitstream word, LSB shifted first.
REQ-009 word_valid  in  1  word_data valid.
REQ-010 word_ready  out  1  loader accepts word this cycle.
REQ-011 config_out  out  1  serial bit to core config_in.
REQ-012 config_enable  out  1  chain shift enable to core.
REQ-013 config_nreset  out  1  chain clear to core, active-low.
REQ-014 core_nreset  out  1  fabric reset to core nreset, active-low.
REQ-015 busy  out  1  high in any state other than IDLE and DONE.
REQ-016 done  out  1  high in DONE, i.e. from load completion until next start or abort.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, LOAD, SHIFT, DONE.
REQ-018 IDLE: start -> CLEAR next cycle; all other inputs ignored.
REQ-019 CLEAR: config_nreset=0 and core_nreset=0 for exactly CLEAR_CYCLES cycles, then -> LOAD.
REQ-020 LOAD: word_ready=1; on word_valid&&word_ready capture word_data into shift register, -> SHIFT next cycle.
REQ-021 SHIFT: config_enable=1, config_out=shift register bit 0; register shifts right by one each cycle.
REQ-022 Bit counter SHALL advance by one per SHIFT cycle; after WORD_WIDTH bits, or when total bits shifted reach CHAIN_LENGTH, leave SHIFT.
REQ-023 Leaving SHIFT: total==CHAIN_LENGTH -> DONE, else -> LOAD.
REQ-024 If CHAIN_LENGTH is not a multiple of WORD_WIDTH, only the low CHAIN_LENGTH mod WORD_WIDTH bits of the last word SHALL be shifted; upper bits discarded.
REQ-025 config_enable SHALL be high for exactly CHAIN_LENGTH cycles per completed load, and never outside SHIFT.
REQ-026 config_out SHALL be 0 whenever config_enable is 0.
REQ-027 Total bit counter width SHALL be clog2(CHAIN_LENGTH+1); no wrap within one load.
REQ-028 DONE: core_nreset=1 and done=1; start -> CLEAR (reload), deasserting done and asserting core_nreset low next cycle.
REQ-029 core_nreset SHALL be 0 in IDLE, CLEAR, LOAD and SHIFT.
REQ-030 config_nreset SHALL be 1 in all states except CLEAR.
REQ-031 start while busy SHALL be ignored.
REQ-032 abort in CLEAR, LOAD or SHIFT -> IDLE next cycle with counters cleared; abort in IDLE or DONE ignored.
REQ-033 abort and start in the same cycle: abort wins; start is dropped.
REQ-034 Word stall (word_valid=0 in LOAD) SHALL hold state with config_enable=0 indefinitely.

Reset
REQ-035 nreset low SHALL asynchronously force state IDLE, counters and shift register 0.
REQ-036 Reset values: word_ready=0, config_out=0, config_enable=0, config_nreset=0, core_nreset=0, busy=0, done=0.
REQ-037 config_nreset SHALL rise to 1 on the first clock edge after nreset deasserts.
REQ-038 Reset mid-load SHALL discard the partial load; no resume.

Structure
REQ-039 Package kfpga_config_pkg SHALL hold the FSM state enum, the default CHAIN_LENGTH and WORD_WIDTH constants.
REQ-040 One sub-module, config_shifter (parallel-load, serial-out register with bit counter), SHALL implement the word serialisation; FSM lives in config_loader.

Verification
REQ-041 CHAIN_LENGTH=64, words 0xA5A5A5A5, 0x0000FFFF, valid always high -> config_enable high 64 cycles, config_out sequence 1,0,1,0,0,1,0,1... then 16 ones, 16 zeros; done=1, core_nreset=1 after.
REQ-042 CHAIN_LENGTH=40, words 0xFFFFFFFF, 0x000000F3 -> 40 enable cycles, last 8 bits 1,1,0,0,1,1,1,1; word_ready asserted exactly twice.
REQ-043 Default parameters, 1084 random words with random valid gaps -> exactly 34688 enable cycles; bit stream equals word stream LSB-first; enable low during every gap.
REQ-044 abort at SHIFT bit 10 of word 3 -> IDLE next cycle, config_enable=0, core_nreset=0, done=0; subsequent start performs full CLEAR and load.
REQ-045 nreset asserted mid-SHIFT -> all outputs at reset values immediately without clock; start during SHIFT and start+abort together -> no state change except abort.
